bg_restore_sequencer: RTL

// - Erases a sprite by redrawing a rectangle of background. Walks the rectangle in raster order, drives
//   (X,Y) into the background-pixel fetch path (sync RAM, fixed read latency), and re-issues each returned

---
 rtl/bg_pkg.sv | 18 +
 rtl/bg_fetch_pipe.sv | 45 ++++
 rtl/bg_restore_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bg_pkg.sv
// rtl/bg_pkg.sv - shared constants and FSM encoding for the background restore sequencer
package bg_pkg;

  localparam int SCREEN_W    = 320;
  localparam int SCREEN_H    = 240;
  localparam int X_W         = 9;
  localparam int Y_W         = 8;
  localparam int COLOR_W     = 3;
  localparam int RAM_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bg_fetch_pipe.sv
// rtl/bg_fetch_pipe.sv - (valid,X,Y) delay line matching the background RAM read latency
module bg_fetch_pipe #(
  parameter int DEPTH = 1,
  parameter int X_W   = 9,
  parameter int Y_W   = 8
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           in_valid,
  input  logic [X_W-1:0] in_x,
  input  logic [Y_W-1:0] in_y,
  output logic           out_valid,
  output logic [X_W-1:0] out_x,
  output logic [Y_W-1:0] out_y
);

  logic [DEPTH-1:0] valid_q;
  logic [X_W-1:0]   x_q [DEPTH];
  logic [Y_W-1:0]   y_q [DEPTH];

  // Shift the issued coordinate tag one stage per clock; stage DEPTH-1 lines up with bg_color.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      x_q[0]     <= in_x;
      y_q[0]     <= in_y;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        x_q[i]     <= x_q[i-1];
        y_q[i]     <= y_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_x     = x_q[DEPTH-1];
  assign out_y     = y_q[DEPTH-1];

endmodule

// File: rtl/bg_restore_sequencer.sv
// rtl/bg_restore_sequencer.sv - raster-walks a clipped rectangle, fetches background and replots it
module bg_restore_sequencer #(
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int COLOR_W     = 3,
  parameter int RAM_LATENCY = 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [8:0]         rect_x,
  input  logic [7:0]         rect_y,
  input  logic [8:0]         rect_w,
  input  logic [7:0]         rect_h,
  output logic [8:0]         bg_x,
  output logic [7:0]         bg_y,
  input  logic [COLOR_W-1:0] bg_color,
  output logic [8:0]         vga_x,
  output logic [7:0]         vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_plot,
  output logic               busy,
  output logic               done
);

  import bg_pkg::*;

  localparam logic [9:0] SCREEN_W10 = 10'(SCREEN_W);
  localparam logic [9:0] SCREEN_H10 = 10'(SCREEN_H);
  localparam logic [1:0] LAST_DRAIN = 2'(RAM_LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [8:0] x_start;
  logic [9:0] x_end;
  logic [9:0] y_end;
  logic [1:0] drain_cnt;

  logic [9:0] x_sum;
  logic [9:0] y_sum;
  logic [9:0] x_end_clip;
  logic [9:0] y_end_clip;
  logic       empty;
  logic       accept;
  logic       last_x;
  logic       last_y;
  logic       issue;

  // Bounds are formed 10 bits wide so a rectangle hanging off the screen edge cannot wrap.
  assign x_sum      = {1'b0, rect_x} + {1'b0, rect_w};
  assign y_sum      = {2'b0, rect_y} + {2'b0, rect_h};
  assign x_end_clip = (x_sum > SCREEN_W10) ? SCREEN_W10 : x_sum;
  assign y_end_clip = (y_sum > SCREEN_H10) ? SCREEN_H10 : y_sum;
  assign empty      = (rect_w == 9'd0) || (rect_h == 8'd0) ||
                      ({1'b0, rect_x} >= SCREEN_W10) || ({2'b0, rect_y} >= SCREEN_H10);
  assign accept     = (state == ST_IDLE) && start;

  assign last_x = (({1'b0, bg_x} + 10'd1) == x_end);
  assign last_y = (({2'b0, bg_y} + 10'd1) == y_end);
  assign issue  = (state == ST_SCAN);

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: empty requests skip straight to DONE; DRAIN waits out the RAM latency.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = empty ? ST_DONE : ST_SCAN;
      ST_SCAN:  if (last_x && last_y) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == LAST_DRAIN) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Latch the clipped job and step the raster counters; bg_x/bg_y hold once the walk ends.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_start   <= '0;
      x_end     <= '0;
      y_end     <= '0;
      bg_x      <= '0;
      bg_y      <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept && !empty) begin
        x_start <= rect_x;
        x_end   <= x_end_clip;
        y_end   <= y_end_clip;
        bg_x    <= rect_x;
        bg_y    <= rect_y;
      end
      if (state == ST_SCAN) begin
        drain_cnt <= '0;
        if (!last_x) begin
          bg_x <= bg_x + 9'd1;
        end else if (!last_y) begin
          bg_x <= x_start;
          bg_y <= bg_y + 8'd1;
        end
      end else if (state == ST_DRAIN) begin
        drain_cnt <= drain_cnt + 2'd1;
      end
    end
  end

  bg_fetch_pipe #(
    .DEPTH (RAM_LATENCY),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_pipe (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (issue),
    .in_x      (bg_x),
    .in_y      (bg_y),
    .out_valid (vga_plot),
    .out_x     (vga_x),
    .out_y     (vga_y)
  );

  // Colour passes straight through from the RAM; forced low between plots so reset reads as zero.
  assign vga_color = vga_plot ? bg_color : '0;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule
